// File: rtl/inst_decode_stage.sv
// Registered RV32I/RV64I instruction-decode stage with valid/ready handshake,
// flush, optional M-extension ALU encoding and a saturating illegal counter.
module inst_decode_stage #(
    parameter int XLEN     = 32,
    parameter int ALUOP_W  = 4,
    parameter int ENABLE_M = 0,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_inst,
    input  logic [XLEN-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_pc,
    output logic [ALUOP_W-1:0] out_alu_op,
    output logic [4:0]         out_rd,
    output logic [4:0]         out_rs1,
    output logic [4:0]         out_rs2,
    output logic [XLEN-1:0]    out_imm,
    output logic               out_reg_we,
    output logic               out_mem_re,
    output logic               out_mem_we,
    output logic               out_branch,
    output logic               out_jump,
    output logic               out_illegal,
    output logic [CNT_W-1:0]   illegal_cnt
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [ALUOP_W-1:0] ALU_ADD     = '0;
    localparam logic [ALUOP_W-1:0] ALU_XOR     = ALUOP_W'(4'b0100);
    localparam logic [ALUOP_W-1:0] ALU_INVALID = '1;

    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [4:0]         rd;
    logic [ALUOP_W-1:0] d_alu_op;
    logic [31:0]        d_imm32;
    logic               d_reg_we;
    logic               d_mem_re;
    logic               d_mem_we;
    logic               d_branch;
    logic               d_jump;
    logic               d_illegal;
    logic               capture;

    assign opcode   = in_inst[6:0];
    assign funct3   = in_inst[14:12];
    assign funct7   = in_inst[31:25];
    assign rd       = in_inst[11:7];
    assign in_ready = !out_valid || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    // Combinational decode of the incoming instruction word.
    always_comb begin
        d_alu_op  = ALU_ADD;
        d_imm32   = 32'h0;
        d_reg_we  = 1'b0;
        d_mem_re  = 1'b0;
        d_mem_we  = 1'b0;
        d_branch  = 1'b0;
        d_jump    = 1'b0;
        d_illegal = 1'b0;
        case (opcode)
            OP_R: begin
                d_reg_we = (rd != 5'd0);
                if (funct7 == 7'b0000000) begin
                    d_alu_op = ALUOP_W'({1'b0, funct3});
                end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    d_alu_op = ALUOP_W'({1'b1, funct3});
                end else if (funct7 == 7'b0000001 && ENABLE_M != 0) begin
                    d_alu_op = ALUOP_W'({2'b10, funct3});
                end else begin
                    d_illegal = 1'b1;
                end
            end
            OP_I: begin
                d_reg_we = (rd != 5'd0);
                d_imm32  = {{20{in_inst[31]}}, in_inst[31:20]};
                d_alu_op = (funct3 == 3'b101) ? ALUOP_W'({funct7[5], funct3})
                                              : ALUOP_W'({1'b0, funct3});
            end
            OP_LOAD: begin
                d_reg_we = (rd != 5'd0);
                d_mem_re = 1'b1;
                d_imm32  = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            OP_STORE: begin
                d_mem_we = 1'b1;
                d_imm32  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            OP_BR: begin
                d_branch = 1'b1;
                d_alu_op = ALU_XOR;
                d_imm32  = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                            in_inst[30:25], in_inst[11:8], 1'b0};
            end
            OP_JAL: begin
                d_reg_we = (rd != 5'd0);
                d_jump   = 1'b1;
                d_imm32  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                            in_inst[20], in_inst[30:21], 1'b0};
            end
            OP_JALR: begin
                d_reg_we = (rd != 5'd0);
                d_jump   = 1'b1;
                d_imm32  = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            OP_LUI, OP_AUIPC: begin
                d_reg_we = (rd != 5'd0);
                d_imm32  = {in_inst[31:12], 12'h000};
            end
            default: begin
                d_illegal = 1'b1;
            end
        endcase
        // An illegal instruction must never cause side effects downstream.
        if (d_illegal) begin
            d_alu_op = ALU_INVALID;
            d_reg_we = 1'b0;
            d_mem_re = 1'b0;
            d_mem_we = 1'b0;
            d_branch = 1'b0;
            d_jump   = 1'b0;
        end
    end

    // Output bundle register: capture on handshake, hold on stall, drop on flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_alu_op  <= '0;
            out_rd      <= '0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_imm     <= '0;
            out_reg_we  <= 1'b0;
            out_mem_re  <= 1'b0;
            out_mem_we  <= 1'b0;
            out_branch  <= 1'b0;
            out_jump    <= 1'b0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid   <= 1'b1;
            out_pc      <= in_pc;
            out_alu_op  <= d_alu_op;
            out_rd      <= rd;
            out_rs1     <= in_inst[19:15];
            out_rs2     <= in_inst[24:20];
            out_imm     <= XLEN'($signed(d_imm32));
            out_reg_we  <= d_reg_we;
            out_mem_re  <= d_mem_re;
            out_mem_we  <= d_mem_we;
            out_branch  <= d_branch;
            out_jump    <= d_jump;
            out_illegal <= d_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Saturating count of illegal instructions actually accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_cnt <= '0;
        end else if (capture && d_illegal && illegal_cnt != '1) begin
            illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

endmodule
